// File: rtl/instruction_loader.sv
// Program loader: takes bytes from the debug UART and writes them into instruction memory,
// assembling big-endian words so that a HALT word ends the load.
module instruction_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFC000000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_write_instruction_mem,
    output logic [31:0]           o_instruction_mem_addr,
    output logic [31:0]           o_instruction_mem_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-2:0] o_word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_reg,      state_next;
    logic [ADDR_WIDTH-1:0] byte_addr_reg,  byte_addr_next;
    logic [1:0]            byte_idx_reg,   byte_idx_next;
    logic [23:0]           word_reg,       word_next;
    logic [ADDR_WIDTH-2:0] word_count_reg, word_count_next;
    logic                  wr_en_reg,      wr_en_next;
    logic [31:0]           mem_addr_reg,   mem_addr_next;
    logic [31:0]           mem_data_reg,   mem_data_next;

    // Only the three preceding bytes of the current group are kept; the incoming
    // byte completes the candidate word, so the match is valid only at index 3.
    logic [31:0] assembled;
    logic [3:0]  lane_match;
    logic        halt_hit;

    assign assembled = {word_reg, i_rx_data};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_match[gi] = (assembled[gi*8 +: 8] == HALT_WORD[gi*8 +: 8]);
        end
    endgenerate

    assign halt_hit = (byte_idx_reg == 2'd3) && (&lane_match);

    always_comb begin
        state_next      = state_reg;
        byte_addr_next  = byte_addr_reg;
        byte_idx_next   = byte_idx_reg;
        word_next       = word_reg;
        word_count_next = word_count_reg;
        wr_en_next      = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;

        case (state_reg)
            LOAD: begin
                if (i_rx_valid) begin
                    wr_en_next     = 1'b1;
                    mem_addr_next  = {{(32-ADDR_WIDTH){1'b0}}, byte_addr_reg};
                    mem_data_next  = {24'd0, i_rx_data};
                    byte_addr_next = byte_addr_reg + 1'b1;
                    byte_idx_next  = byte_idx_reg + 1'b1;
                    word_next      = assembled[23:0];
                    if (byte_idx_reg == 2'd3) begin
                        word_count_next = word_count_reg + 1'b1;
                    end
                    if (halt_hit) begin
                        state_next = DONE;
                    end else if (byte_addr_reg == LAST_ADDR) begin
                        // Memory exhausted without a HALT: the byte is still written,
                        // but the address counter is never allowed to be reused.
                        state_next = ERROR;
                    end
                end
            end
            default: begin
                // A byte arriving together with i_start is deliberately dropped.
                if (i_start) begin
                    state_next      = LOAD;
                    byte_addr_next  = '0;
                    byte_idx_next   = '0;
                    word_next       = '0;
                    word_count_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            byte_addr_reg  <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            word_count_reg <= '0;
            wr_en_reg      <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            byte_addr_reg  <= byte_addr_next;
            byte_idx_reg   <= byte_idx_next;
            word_reg       <= word_next;
            word_count_reg <= word_count_next;
            wr_en_reg      <= wr_en_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
        end
    end

    assign o_write_instruction_mem = wr_en_reg;
    assign o_instruction_mem_addr  = mem_addr_reg;
    assign o_instruction_mem_data  = mem_data_reg;
    assign o_busy                  = (state_reg == LOAD);
    assign o_done                  = (state_reg == DONE);
    assign o_error                 = (state_reg == ERROR);
    assign o_word_count            = word_count_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed table-driven bench for instruction_loader: each record gives one cycle of inputs
// and the outputs expected just after the clock edge that consumes them.
module tb_instruction_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  wc;

    int tests_run = 0;
    int tests_failed = 0;

    instruction_loader #(.ADDR_WIDTH(8), .HALT_WORD(32'hFC000000)) dut (
        .i_clk                   (clk),
        .i_reset                 (rst),
        .i_start                 (start),
        .i_rx_valid              (valid),
        .i_rx_data               (data),
        .o_write_instruction_mem (we),
        .o_instruction_mem_addr  (maddr),
        .o_instruction_mem_data  (mdata),
        .o_busy                  (busy),
        .o_done                  (done),
        .o_error                 (err),
        .o_word_count            (wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        done;
        logic        err;
        logic [6:0]  wc;
    } vec_t;

    vec_t vq[$];

    logic [7:0] prog_a    [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
    logic [7:0] prog_b    [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFC, 8'h00, 8'h00, 8'h00};
    logic [7:0] straddle  [8] = '{8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};

    task automatic add(input logic r, input logic s, input logic v, input logic [7:0] d,
                       input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_data,
                       input logic e_busy, input logic e_done, input logic e_err, input logic [6:0] e_wc);
        vec_t t;
        t.rst = r; t.start = s; t.valid = v; t.data = d;
        t.we = e_we; t.addr = e_addr; t.wdata = e_data;
        t.busy = e_busy; t.done = e_done; t.err = e_err; t.wc = e_wc;
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r; start = s; valid = v; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_we, input logic [31:0] e_addr,
                         input logic [31:0] e_data, input logic e_busy, input logic e_done,
                         input logic e_err, input logic [6:0] e_wc);
        tests_run++;
        if ({we, maddr, mdata, busy, done, err, wc} !== {e_we, e_addr, e_data, e_busy, e_done, e_err, e_wc}) begin
            tests_failed++;
            $display("FAIL %s: got we=%b addr=%h data=%h busy=%b done=%b err=%b wc=%0d, want we=%b addr=%h data=%h busy=%b done=%b err=%b wc=%0d",
                     name, we, maddr, mdata, busy, done, err, wc,
                     e_we, e_addr, e_data, e_busy, e_done, e_err, e_wc);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00;

        // Reset, then a byte in IDLE must be ignored.
        add(1,0,0,8'h00, 0,0,0, 0,0,0,0);
        add(0,0,1,8'h33, 0,0,0, 0,0,0,0);

        // Slow load, one byte every third cycle, ending in HALT.
        add(0,1,0,8'h00, 0,0,0, 1,0,0,0);
        for (int i = 0; i < 8; i++) begin
            add(0,0,1,prog_a[i], 1,i,{24'd0,prog_a[i]}, i != 7, i == 7, 0, 7'((i + 1) / 4));
            for (int k = 0; k < 2; k++)
                add(0,0,0,8'h00, 0,i,{24'd0,prog_a[i]}, i != 7, i == 7, 0, 7'((i + 1) / 4));
        end

        // Back-to-back load from DONE; i_start during LOAD must be ignored.
        add(0,1,0,8'h00, 0,7,0, 1,0,0,0);
        for (int i = 0; i < 8; i++)
            add(0, i == 3, 1, prog_b[i], 1,i,{24'd0,prog_b[i]}, i != 7, i == 7, 0, 7'((i + 1) / 4));

        // Start with a coincident byte in DONE: byte dropped, next byte lands at 0.
        add(0,1,1,8'hAA, 0,7,0, 1,0,0,0);
        add(0,0,1,8'h12, 1,0,32'h12, 1,0,0,0);

        // HALT pattern straddling a group boundary must not terminate the load.
        add(1,0,0,8'h00, 0,0,0, 0,0,0,0);
        add(0,1,0,8'h00, 0,0,0, 1,0,0,0);
        for (int i = 0; i < 8; i++)
            add(0,0,1,straddle[i], 1,i,{24'd0,straddle[i]}, 1,0,0, 7'((i + 1) / 4));
        add(0,0,0,8'h00, 0,7,32'h33, 1,0,0,2);

        // Fill the whole memory with zeros: ERROR on the last byte, no wrap afterwards.
        add(1,0,0,8'h00, 0,0,0, 0,0,0,0);
        add(0,1,0,8'h00, 0,0,0, 1,0,0,0);
        for (int i = 0; i < 256; i++)
            add(0,0,1,8'h00, 1,i,0, i != 255, 0, i == 255, 7'((i + 1) / 4));
        add(0,0,1,8'h77, 0,255,0, 0,0,1,64);
        add(0,0,1,8'h78, 0,255,0, 0,0,1,64);
        add(0,1,0,8'h00, 0,255,0, 1,0,0,0);
        add(0,0,1,8'h5A, 1,0,32'h5A, 1,0,0,0);

        for (int n = 0; n < vq.size(); n++) begin
            drive(vq[n].rst, vq[n].start, vq[n].valid, vq[n].data);
            check($sformatf("vec%0d", n), vq[n].we, vq[n].addr, vq[n].wdata,
                  vq[n].busy, vq[n].done, vq[n].err, vq[n].wc);
        end

        // Reset in the middle of a load aborts it; later bytes without i_start are ignored.
        drive(1,0,0,8'h00);
        drive(0,1,0,8'h00);
        for (int i = 0; i < 5; i++) begin
            drive(0,0,1,8'(i + 1));
            check($sformatf("midload_byte%0d", i), 1, i, i + 1, 1,0,0,
                  7'((i + 1) / 4));
        end
        drive(1,0,1,8'h99);
        check("midload_reset", 0,0,0, 0,0,0,0);
        drive(0,0,1,8'h42);
        check("after_reset_byte0", 0,0,0, 0,0,0,0);
        drive(0,0,1,8'h43);
        check("after_reset_byte1", 0,0,0, 0,0,0,0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, instruction-memory byte-address width (2^ADDR_WIDTH bytes).
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFC000000, instruction word that ends a program load.
REQ-003 The block SHALL have port i_clk  input  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port i_start  input  1  single-cycle request to begin a new load.
REQ-006 The block SHALL have port i_rx_valid  input  1  single-cycle strobe: i_rx_data holds one new program byte.
REQ-007 The block SHALL have port i_rx_data  input  8  program byte from the debug-unit UART receiver.
REQ-008 The block SHALL have port o_write_instruction_mem  output  1  instruction-memory write enable, one cycle per byte.
REQ-009 The block SHALL have port o_instruction_mem_addr  output  32  byte address, zero-extended from ADDR_WIDTH bits.
REQ-010 The block SHALL have port o_instruction_mem_data  output  32  written byte in bits [7:0], bits [31:8] zero.
REQ-011 The block SHALL have port o_busy  output  1  high while in LOAD.
REQ-012 The block SHALL have port o_done  output  1  high while in DONE.
REQ-013 The block SHALL have port o_error  output  1  high while in ERROR (memory full without HALT).
REQ-014 The block SHALL have port o_word_count  output  ADDR_WIDTH-1  number of complete 4-byte words written in the current load.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, DONE, ERROR; all outputs registered.
REQ-016 IDLE/DONE/ERROR: i_start SHALL move to LOAD next cycle, clearing byte address, byte-in-word index, word shift register and o_word_count.
REQ-017 LOAD: i_start SHALL be ignored; i_rx_valid in IDLE/DONE/ERROR SHALL be ignored and produce no write.
REQ-018 LOAD: a byte accepted (i_rx_valid=1) in cycle N SHALL produce o_write_instruction_mem=1 in cycle N+1 with address = current byte address and data = that byte.
REQ-019 o_write_instruction_mem SHALL be 0 in every cycle not following an accepted byte; back-to-back i_rx_valid SHALL give back-to-back writes at consecutive addresses.
REQ-020 Byte address SHALL increment by 1 after each accepted byte; bytes are stored in arrival order.
REQ-021 Words SHALL be assembled big-endian: first byte of a 4-byte group is bits [31:24].
REQ-022 On acceptance of the 4th byte of a group, o_word_count SHALL increment, and if the assembled word equals HALT_WORD the FSM SHALL enter DONE in cycle N+1 (same cycle as that byte's write).
REQ-023 HALT_WORD SHALL only be matched on 4-byte-aligned groups, never across group boundaries.
REQ-024 If the byte at address 2^ADDR_WIDTH-1 is accepted and does not complete a HALT_WORD, that byte SHALL still be written and the FSM SHALL enter ERROR in cycle N+1; address SHALL NOT wrap.
REQ-025 i_start coincident with i_rx_valid in DONE/ERROR SHALL start a new load and discard that byte.
REQ-026 o_instruction_mem_addr and o_instruction_mem_data SHALL hold their last values when no write is issued.

Reset
REQ-027 i_reset SHALL take priority over all inputs, including mid-load, and abort any load.
REQ-028 After reset: state IDLE, o_write_instruction_mem=0, o_instruction_mem_addr=0, o_instruction_mem_data=0, o_busy=0, o_done=0, o_error=0, o_word_count=0, internal word register 0.

Verification
REQ-029 Start, bytes 20 01 00 05, FC 00 00 00 one per 3 cycles -> 8 single-cycle writes at addr 0..7 with those bytes; o_done=1 the cycle of the addr-7 write; o_word_count=2.
REQ-030 Start, 8 back-to-back valid bytes ending in HALT_WORD -> 8 consecutive write cycles, addr 0..7, no gaps; DONE after the last.
REQ-031 Start, bytes 00 FC 00 00 00 11 22 33 (HALT straddling groups) -> no DONE; o_busy stays 1, o_word_count=2.
REQ-032 Start, 256 bytes of 00 -> writes at 0..255, ERROR the cycle of the addr-255 write, further bytes produce no writes; i_start then -> LOAD with addr 0.
REQ-033 i_reset asserted after 5 bytes of a load -> all outputs at reset values next cycle; subsequent bytes without i_start ignored.
REQ-034 In DONE, i_start and i_rx_valid same cycle with data AA -> LOAD entered, no write of AA, next byte written at addr 0.
